// File: rtl/rnbip_pkg.sv
// Shared RNBIP-2 definitions: datapath widths, NOP encoding, instruction field
// positions and the fetch FSM state type.
package rnbip_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 8;
  localparam int FSEL_MSB = 10;
  localparam int FSEL_LSB = 8;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO for the fetch stage: circular buffer with push, pop, flush,
// full/empty flags, an occupancy count and a combinational head.
module ifetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             din_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ifetch_stage.sv
// RNBIP-2 instruction-fetch stage: PC, fetch FSM, prefetch queue and output mux.
// Optional macro IFETCH_BUBBLE_CNT_EN enables the saturating bubble counter.
module ifetch_stage #(
  parameter int PC_W    = rnbip_pkg::PC_W,
  parameter int INSTR_W = rnbip_pkg::INSTR_W,
  parameter int QDEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               l_pc,
  input  logic [PC_W-1:0]    pc_target,
  input  logic [7:0]         flags_in,
  input  logic               stall,
  output logic [INSTR_W-1:0] segment,
  output logic [PC_W-1:0]    npc,
  output logic               fl,
  output logic               valid,
  output logic [7:0]         bubble_cnt
);

  import rnbip_pkg::*;

  localparam int ENTRY_W = INSTR_W + PC_W;
  localparam int CNT_W   = $clog2(QDEPTH+1);
  localparam int OCC_W   = CNT_W + 1;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W-1:0]   q_count;
  logic               q_full, q_empty;
  logic               push, pop;
  logic [OCC_W-1:0]   occ_next;

  assign imem_addr = pc_q;

  // Head is presented combinationally so a word acked at edge N is visible right after N.
  assign valid   = !q_empty && !l_pc;
  assign pop     = valid && !stall;
  assign segment = valid ? q_head[ENTRY_W-1:PC_W] : INSTR_W'(NOP_INSTR);
  assign npc     = valid ? q_head[PC_W-1:0] : '0;
  assign fl      = flags_in[segment[FSEL_MSB:FSEL_LSB]];

  assign push     = (state_q == ST_FETCH) && imem_ack && !l_pc && (!q_full || pop);
  assign occ_next = OCC_W'(q_count) + OCC_W'(push) - OCC_W'(pop);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = rst_n;
      ST_HOLD:  imem_req = 1'b0;
      default:  imem_req = 1'b0;
    endcase
    if (l_pc) begin
      pc_d    = pc_target;
      state_d = ST_FETCH;
    end else begin
      if (push) pc_d = pc_q + PC_W'(1);
      state_d = (occ_next == OCC_W'(QDEPTH)) ? ST_HOLD : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (l_pc),
    .din_i   ({imem_rdata, pc_q + PC_W'(1)}),
    .dout_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

`ifdef IFETCH_BUBBLE_CNT_EN
  logic [7:0] bcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
    end else if (!stall && !valid && (bcnt_q != 8'hFF)) begin
      bcnt_q <= bcnt_q + 8'd1;
    end
  end

  assign bubble_cnt = bcnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomised scoreboard bench for ifetch_stage: the stimulus side records every
// accepted fetch in an expected-instruction queue, the monitor consumes it.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        l_pc = 1'b0;
  logic [7:0]  pc_target = 8'h0;
  logic [7:0]  flags_in = 8'h0;
  logic        stall = 1'b0;
  logic [15:0] segment;
  logic [7:0]  npc;
  logic        fl;
  logic        valid;
  logic [7:0]  bubble_cnt;

  ifetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .l_pc       (l_pc),
    .pc_target  (pc_target),
    .flags_in   (flags_in),
    .stall      (stall),
    .segment    (segment),
    .npc        (npc),
    .fl         (fl),
    .valid      (valid),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam int QDEPTH = 2;

  logic [15:0] mem [256];
  logic [23:0] exp_q [$];   // {instr, npc} of words fetched but not yet consumed
  logic [7:0]  mpc = 8'h0;  // address the next fetch must use
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, expv, $time);
    end
  endfunction

  // One clock of memory/control stimulus; the model is advanced at the edge.
  task automatic drive(input int ackp, input int stallp, input int lpcp, input logic [7:0] tgt);
    logic a, lp;
    @(negedge clk);
    a  = imem_req && (int'($urandom_range(99)) < ackp);
    lp = (int'($urandom_range(99)) < lpcp);
    imem_ack   = a;
    imem_rdata = a ? mem[mpc] : 16'($urandom);
    stall      = (int'($urandom_range(99)) < stallp);
    l_pc       = lp;
    pc_target  = tgt;
    @(posedge clk);
    if (lp) begin
      exp_q.delete();
      mpc = tgt;
    end else if (a) begin
      exp_q.push_back({mem[mpc], mpc + 8'd1});
      mpc = mpc + 8'd1;
    end
  endtask

  initial begin : monitor
    logic [7:0]  mbc;
    logic        ev;
    logic [23:0] head;
    mbc = 8'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mbc = 8'h0;
        check("rst_imem_req",   32'(imem_req),   32'h0);
        check("rst_valid",      32'(valid),      32'h0);
        check("rst_segment",    32'(segment),    32'h0);
        check("rst_npc",        32'(npc),        32'h0);
        check("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
      end else begin
        ev   = (exp_q.size() != 0) && !l_pc;
        head = ev ? exp_q[0] : 24'h0;
        check("imem_req", 32'(imem_req), 32'(exp_q.size() < QDEPTH));
        if (exp_q.size() < QDEPTH) check("imem_addr", 32'(imem_addr), 32'(mpc));
        check("valid",   32'(valid),   32'(ev));
        check("segment", 32'(segment), 32'(head[23:8]));
        check("npc",     32'(npc),     32'(head[7:0]));
        check("fl",      32'(fl),      32'(flags_in[head[18:16]]));
`ifdef IFETCH_BUBBLE_CNT_EN
        check("bubble_cnt", 32'(bubble_cnt), 32'(mbc));
        if (!stall && !ev && mbc != 8'hFF) mbc = mbc + 8'd1;
`else
        check("bubble_cnt", 32'(bubble_cnt), 32'h0);
`endif
        if (ev && !stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    mem[8'h50] = 16'h0A33;
    mem[8'h51] = 16'h0955;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (10) drive(100, 0, 0, 8'h00);      // zero-wait streaming
    repeat (4)  drive(100, 100, 0, 8'h00);    // stall fills queue, request drops
    repeat (6)  drive(100, 0, 0, 8'h00);      // drain in order
    drive(100, 0, 100, 8'h40);                // redirect with a same-cycle ack
    repeat (6)  drive(100, 0, 0, 8'h00);
    flags_in = 8'b0000_0100;
    drive(100, 0, 100, 8'h50);                // opcodes 0x0A then 0x09
    repeat (4)  drive(100, 0, 0, 8'h00);
    drive(100, 0, 100, 8'hFE);                // PC wrap through 0xFF
    repeat (5)  drive(100, 0, 0, 8'h00);
    flags_in = 8'h00;
    repeat (300) drive(0, 0, 0, 8'h00);       // long starvation saturates the counter

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    imem_ack = 1'b0;
    l_pc     = 1'b0;
    stall    = 1'b0;
    #1 rst_n = 1'b0;
    exp_q.delete();
    mpc = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    repeat (500) begin
      flags_in = 8'($urandom);
      drive(60, 30, 4, 8'($urandom));
    end
    repeat (6) drive(100, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the 3-stage pipelined RNBIP-2 processor, directly upstream of the first control-code-generator stage. Owns the program counter and issues requests to instruction memory, buffering returned 16-bit instruction words in a small prefetch queue. Presents `{opcode, operand}`, next-PC and the selected condition flag for the downstream stage to latch. Handles PC redirects (jumps, calls, returns) by flushing and injecting NOP bubbles.

## Interface
- `PC_W`, default 8: program-counter and instruction-address width.
- `INSTR_W`, default 16: instruction width; bits [15:8] opcode, [7:0] operand.
- `QDEPTH`, default 2: prefetch-queue entries, power of two, minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `imem_req` out 1: fetch request; held with a stable address until acknowledged.
- `imem_addr` out PC_W: fetch address (current PC).
- `imem_ack` in 1: single-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in INSTR_W: returned instruction word.
- `l_pc` in 1: PC load (redirect) from the execute-stage control.
- `pc_target` in PC_W: redirect target from the PC mux.
- `flags_in` in 8: processor flag register.
- `stall` in 1: downstream hold; no queue pop while high.
- `segment` out INSTR_W: instruction presented downstream.
- `npc` out PC_W: address of the presented instruction plus 1.
- `fl` out 1: `flags_in[segment[10:8]]`, evaluated combinationally.
- `valid` out 1: high when `segment` is a real instruction and not a bubble.
- `bubble_cnt` out 8: bubble counter (see Configuration).

## Operation
- Queue entry = `{instr, npc}`; circular buffer with read/write pointers and an occupancy count of 0..QDEPTH.
- Fetch FSM states:
  - **FETCH**: `imem_req`=1, `imem_addr`=PC. On `imem_ack`, the entry `{imem_rdata, PC+1}` is pushed and PC<=PC+1.
  - **HOLD**: `imem_req`=0. Entered when the queue will be full after this cycle's push/pop; leaves to FETCH as soon as a slot frees.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 = 0x00, and `npc` wraps the same way.
- Output mux:
  - Queue non-empty and `l_pc`=0: present the queue head with `valid`=1.
  - Otherwise: present a bubble with `segment`=16'h0000 (NOP), `npc`=0, `valid`=0.
- Pop occurs when head is valid, `stall`=0 and `l_pc`=0. Push and pop in the same cycle are allowed even at full occupancy; the count is unchanged.
- Redirect (`l_pc`=1) has priority over everything:
  - Queue is flushed (count<=0) and PC<=`pc_target`.
  - An `imem_ack` arriving in the same cycle is discarded.
  - FSM goes to FETCH. The next cycle requests `pc_target`.
- `stall` together with `l_pc`: redirect wins, and the bubble is presented.
- `stall` has no effect on fetch except through queue fullness.

## Timing
- Reset values: PC=0, queue empty, FSM=FETCH, `imem_req`=0 while `rst_n`=0; `segment`=0, `npc`=0, `valid`=0, `bubble_cnt`=0.
- First `imem_req` is asserted in the first cycle after `rst_n` deasserts, with `imem_addr`=0x00.
- Fetch-to-present latency: an instruction acked at edge N is visible on `segment` after edge N (head comb path). The downstream stage latches it at edge N+1.
- Zero-wait memory (ack every cycle) sustains 1 instruction/cycle with no bubbles.
- Redirect penalty: at least 2 bubble cycles (the redirect cycle, then the fetch of the target).
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

## Configuration
- `IFETCH_BUBBLE_CNT_EN` defined: `bubble_cnt` increments every cycle in which `stall`=0 and a bubble is presented. It saturates at 0xFF and is cleared only by reset.
- Not defined: no counter logic; `bubble_cnt` is tied to 0.

## Structure
- Shared package `rnbip_pkg` holds:
  - `PC_W` and `INSTR_W` constants.
  - `NOP_INSTR` = 16'h0000.
  - The fetch FSM state enum.
  - The opcode-field slice localparams ([15:8] opcode, [10:8] flag select).
- One sub-module, `ifetch_queue`: a parameterised synchronous FIFO with push, pop, flush, full, empty and head data. The PC and FSM stay in `ifetch_stage`.

## Test plan
- Reset release, ack every cycle, rdata = 0x1000+addr: addresses 0,1,2… requested back-to-back. `segment` = 0x1000, 0x1001… on consecutive cycles with `npc`=addr+1 and `valid`=1.
- `stall` held 4 cycles with ack always high: `imem_req` drops after the queue fills (2 entries). On release, the held instructions emerge in order with no loss or duplication.
- `l_pc`=1, `pc_target`=0x40 while an ack arrives in the same cycle: the acked word is never presented. Bubbles (`segment`=0, `valid`=0) appear, then `imem_addr`=0x40 and `segment`=word@0x40.
- PC at 0xFF: the fetch returns `npc`=0x00 and the next `imem_addr`=0x00.
- `flags_in`=8'b0000_0100 with an instruction whose opcode is 0x0A: `fl`=1. With opcode 0x09: `fl`=0.
- With `IFETCH_BUBBLE_CNT_EN`, ack held low for 300 cycles: `bubble_cnt` saturates at 0xFF. Without the macro it stays 0.
